// File: rtl/step_controller.sv
// Run/halt/single-step sequencer: conditions the step button and run switch and
// produces a registered datapath advance enable, with PC breakpoint and retire counter.
module step_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_step_btn,
    input  logic        i_run_sw,
    input  logic        i_bp_en,
    input  logic [15:0] i_bp_addr,
    input  logic [15:0] i_pc,
    input  logic        i_instr_done,
    output logic        o_cpu_en,
    output logic        o_halted,
    output logic        o_bp_hit,
    output logic [1:0]  o_state,
    output logic [15:0] o_instr_count
);

    localparam logic [1:0] S_HALT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STEP  = 2'd2;
    localparam logic [1:0] S_BREAK = 2'd3;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_step_sync;
    logic [1:0]       r_run_sync;
    logic [CNT_W-1:0] r_db_cnt;
    logic             r_btn_acc;
    logic             r_btn_acc_d;
    logic             r_step_pulse;
    logic [1:0]       r_state;
    logic [15:0]      r_instr_count;

    logic             w_step_s;
    logic             w_run_s;
    logic             w_retire;
    logic             w_bp_match;
    logic [1:0]       w_state_nxt;

    assign w_step_s   = r_step_sync[1];
    assign w_run_s    = r_run_sync[1];
    assign w_retire   = i_instr_done && o_cpu_en;
    assign w_bp_match = i_bp_en && (i_pc == i_bp_addr);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_step_sync  <= 2'b00;
            r_run_sync   <= 2'b00;
            r_db_cnt     <= '0;
            r_btn_acc    <= 1'b0;
            r_btn_acc_d  <= 1'b0;
            r_step_pulse <= 1'b0;
        end else begin
            r_step_sync  <= {r_step_sync[0], i_step_btn};
            r_run_sync   <= {r_run_sync[0], i_run_sw};
            r_btn_acc_d  <= r_btn_acc;
            r_step_pulse <= r_btn_acc && !r_btn_acc_d;
            // Any cycle where the synced input agrees with the accepted level restarts the window
            if (w_step_s == r_btn_acc) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_btn_acc <= w_step_s;
                r_db_cnt  <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HALT: begin
                if (w_run_s)           w_state_nxt = S_RUN;
                else if (r_step_pulse) w_state_nxt = S_STEP;
            end
            S_STEP: begin
                if (w_retire) w_state_nxt = S_HALT;
            end
            S_RUN: begin
                // Breakpoint outranks a stop request on the same retire
                if (w_retire && w_bp_match) w_state_nxt = S_BREAK;
                else if (w_retire && !w_run_s) w_state_nxt = S_HALT;
            end
            default: begin
                if (!w_run_s)          w_state_nxt = S_HALT;
                else if (r_step_pulse) w_state_nxt = S_STEP;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_HALT;
            r_instr_count <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_retire) r_instr_count <= r_instr_count + 16'h0001;
        end
    end

    assign o_state       = r_state;
    assign o_cpu_en      = (r_state == S_RUN) || (r_state == S_STEP);
    assign o_halted      = (r_state == S_HALT) || (r_state == S_BREAK);
    assign o_bp_hit      = (r_state == S_BREAK);
    assign o_instr_count = r_instr_count;

endmodule
